// File: rtl/int_div_unit.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration phase.
module int_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            p_start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            div_unit_busy,
  output logic            p_last,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  dvsr_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             spec_q;
  logic [XLEN-1:0]  spec_res_q;

  // Magnitude of a signed operand; INT_MIN maps onto itself, read as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_sgn);
    return (is_sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic            acc_sgn;
  logic            acc_div0;
  logic            acc_ovf;
  logic            acc_spec;
  logic [XLEN-1:0] acc_spec_res;
  logic            accept;

  always_comb begin
    acc_sgn      = ~op[0];
    acc_div0     = (rs2_data == '0);
    acc_ovf      = acc_sgn && (rs1_data == INT_MIN) && (rs2_data == '1);
    acc_spec     = acc_div0 | acc_ovf;
    acc_spec_res = '0;
    if (acc_div0)
      acc_spec_res = op[1] ? rs1_data : '1;
    else if (acc_ovf)
      acc_spec_res = op[1] ? '0 : INT_MIN;
  end

  assign accept = (state == S_IDLE) && p_start && !flush;

  // One restoring step: shift {rem, quo}, trial-subtract on XLEN+1 bits.
  logic        [XLEN:0] rem_sh;
  logic signed [XLEN:0] trial;
  logic                 trial_ok;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    trial    = $signed(rem_sh) - $signed({1'b0, dvsr_q});
    trial_ok = ~trial[XLEN];
  end

  logic [XLEN-1:0] fix_res;

  always_comb begin
    if (spec_q)
      fix_res = spec_res_q;
    else if (op_q[1])
      fix_res = cond_neg(rem_q, neg_r_q);
    else
      fix_res = cond_neg(quo_q, neg_q_q);
  end

  // Control: state, counter and the architecturally visible outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (p_start) begin
            cnt <= '0;
`ifdef DIV_EARLY_OUT_EN
            // Special cases already hold their answer; go straight to the result register.
            state <= acc_spec ? S_FIX : S_CALC;
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          rd_out <= rd_q;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: operands latched on accept, iterated during CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= op;
      rd_q       <= rd_in;
      dvsr_q     <= mag(rs2_data, acc_sgn);
      quo_q      <= mag(rs1_data, acc_sgn);
      rem_q      <= '0;
      neg_q_q    <= acc_sgn & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
      neg_r_q    <= acc_sgn & rs1_data[XLEN-1];
      spec_q     <= acc_spec;
      spec_res_q <= acc_spec_res;
    end else if (state == S_CALC) begin
      rem_q <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], trial_ok};
    end
  end

  assign div_unit_busy = (state != S_IDLE);
  assign p_last        = (state == S_DONE);

endmodule

// File: tb/tb_int_div_unit.sv
// Bench for int_div_unit: directed RV32M cases plus randomized traffic against a
// cycle-level behavioural model (latency counter + arithmetic reference).
module tb_int_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_N = 33;
  localparam int LAT_S = EARLY ? 1 : 33;

  logic        clk;
  logic        reset_n;
  logic        p_start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic        div_unit_busy;
  logic        p_last;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int shown  = 0;

  int_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .p_start(p_start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .flush(flush),
    .div_unit_busy(div_unit_busy), .p_last(p_last), .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model: m_left counts the cycles the unit stays occupied; the final one is the p_last cycle.
  bit          mvalid = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] pend_res;
  logic [4:0]  pend_rd;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_left = 0;
      m_res  = '0;
      m_rd   = '0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 1) begin
            m_res = pend_res;
            m_rd  = pend_rd;
          end
        end
      end else if (p_start && !flush) begin
        pend_res = ref_div(op, rs1_data, rs2_data);
        pend_rd  = rd_in;
        m_left   = (EARLY && is_special(op, rs1_data, rs2_data)) ? 2 : LAT_N + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (div_unit_busy !== (m_left > 0) || p_last !== (m_left == 1) ||
          result !== m_res || rd_out !== m_rd) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle_model t=%0t busy %b want %b last %b want %b result %h want %h rd %0d want %0d",
                   $time, div_unit_busy, (m_left > 0), p_last, (m_left == 1), result, m_res, rd_out, m_rd);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_r, input int exp_lat,
                       input bit hold, input bit start_in_done);
    int lat;
    bit seen;
    op = o; rs1_data = a; rs2_data = b; rd_in = rd; p_start = 1'b1;
    cyc(1);
    if (hold) begin
      rs1_data = 32'd999; rs2_data = 32'd1; rd_in = ~rd;
    end else p_start = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (p_last) seen = 1'b1;
      else begin
        cyc(1);
        lat++;
        if (lat >= 20) p_start = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL p_last_timeout op %0d got none expected latency %0d", o, exp_lat);
    end else begin
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("result", result, exp_r);
      chk("rd_out", 32'(rd_out), 32'(rd));
      if (start_in_done) begin
        op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_in = 5'd30; p_start = 1'b1;
      end
    end
    cyc(1);
    p_start = 1'b0;
    if (start_in_done) begin
      @(negedge clk);
      chk("done_start_ignored", 32'(div_unit_busy), 32'd0);
      cyc(1);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    int fk;
    int k;
    reset_n = 1'b0; p_start = 1'b0; op = 2'b00; rs1_data = '0; rs2_data = '0;
    rd_in = '0; flush = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {div_unit_busy, p_last, rd_out, result[24:0]}, 32'd0);
    chk("reset_result", result, 32'd0);
    cyc(1);

    chk("model_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
    chk("model_remu", ref_div(2'b11, 32'd100, 32'd7), 32'd2);
    chk("model_div_neg", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_neg", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_rem_negdiv", ref_div(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
    chk("model_ovf_div", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    do_op(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, LAT_N, 1'b0, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 5'd4, 32'd2, LAT_N, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, LAT_N, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, LAT_N, 1'b0, 1'b0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, LAT_N, 1'b0, 1'b0);
    do_op(2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, LAT_S, 1'b0, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 5'd9, 32'd5, LAT_S, 1'b0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, LAT_S, 1'b0, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, LAT_S, 1'b0, 1'b0);

    // Flush mid-divide: result keeps the previous REM value of 0.
    op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd12; p_start = 1'b1;
    cyc(1);
    p_start = 1'b0;
    cyc(9);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(div_unit_busy), 32'd0);
    chk("flush_result_hold", result, 32'd0);
    cyc(1);
    do_op(2'b01, 32'd1000, 32'd3, 5'd12, 32'd333, LAT_N, 1'b0, 1'b0);

    // Reset in the middle of a divide.
    op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd13; p_start = 1'b1;
    cyc(1);
    p_start = 1'b0;
    cyc(19);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {27'd0, div_unit_busy, p_last, 3'd0} | 32'(rd_out), 32'd0);
    chk("midreset_result", result, 32'd0);
    cyc(1);

    do_op(2'b01, 32'd50, 32'd5, 5'd14, 32'd10, LAT_N, 1'b1, 1'b0);
    do_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFF2, LAT_N, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 9);
      fk = $urandom_range(1, 36);
      op = 2'($urandom_range(0, 3)); rs1_data = pick(); rs2_data = pick();
      rd_in = 5'($urandom); p_start = 1'b1;
      cyc(1);
      p_start = 1'b0;
      k = 1;
      while (m_left > 0 && k < 45) begin
        flush = (mode == 0 && k == fk);
        if (mode == 1) begin
          p_start = 1'($urandom); rs1_data = $urandom; rs2_data = pick(); rd_in = 5'($urandom);
        end
        cyc(1);
        k++;
      end
      flush = 1'b0;
      p_start = 1'b0;
      cyc($urandom_range(0, 3));
    end

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
